decoder_scan_ctrl: RTL and testbench
====================================

# decoder_scan_ctrl

Sequential address generator that sits directly upstream of the 3-to-8 decoder and drives its `A[2:0]` and `E` inputs. It steps through all eight decoder outputs, holds each one active for a programmable dwell time, and inserts a blanking gap between addresses so that `A` never changes while `E` is high. It supports continuous or one-shot sweeps, up or down direction, and start/stop control with status pulses. Typical use is scanning LED or digit enables.

## Interface
- `DWELL_W`, default 8: width of the dwell-time input and dwell counter.
- `BLANK_CYC`, default 1: cycles with `E`=0 between consecutive addresses. Legal range is 1..15; 0 is illegal.

- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE.
- `stop`, in, 1: abort the sweep. Sampled in every state.
- `oneshot`, in, 1: 1 = single sweep, 0 = continuous. Latched at start.
- `dir`, in, 1: 0 = up (0→7), 1 = down (7→0). Latched at start.
- `dwell`, in, DWELL_W: cycles `E` stays high per address. Latched at start; 0 is treated as 1.
- `A`, out, 3: decoder address. Registered.
- `E`, out, 1: decoder enable. Registered.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse when a one-shot sweep ends.
- `wrap`, out, 1: one-cycle pulse when a continuous sweep wraps past the last address.

## Operation
- **Reset:** state = IDLE, `A`=0, `E`=0, `busy`=0, `done`=0, `wrap`=0. All latched config and counters are cleared. Reset asserted mid-sweep forces these values immediately, with no completion pulse.
- **IDLE:**
  - `E`=0; `A` holds its last value.
  - `start`=1 with `stop`=0: latch `oneshot`, `dir` and `dwell`; load `A` = 0 (up) or 7 (down); go to BLANK.
- **BLANK:**
  - `E`=0 for exactly BLANK_CYC cycles, then go to DRIVE.
- **DRIVE:**
  - `E`=1 for exactly max(dwell,1) cycles.
  - On leaving, the next action depends on the address:
    - Not the last address: step `A` by ±1 and go to BLANK.
    - Last address (7 up / 0 down) and one-shot: go to IDLE, pulse `done`.
    - Last address and continuous: wrap `A` (7→0 or 0→7), pulse `wrap`, go to BLANK.
- **Stop:**
  - `stop`=1 in any state: next cycle state = IDLE and `E`=0. No `done` or `wrap` pulse; `A` holds.
  - `stop` has priority over `start` and over the end-of-DRIVE transition.
- `start` while busy is ignored.
- Changes to `oneshot`, `dir` or `dwell` while busy have no effect until the next start.
- **Invariant:** `A` changes only on the edge where `E` is 0 after the edge. `A` and `E` never change together with `E` ending high.

## Timing
- Reference point: `start` sampled at edge k.
  - `A` is valid and `busy`=1 after edge k; `E`=0.
  - `E` rises after edge k+BLANK_CYC.
  - `E` is high for dwell edges and falls together with the `A` step.
- Period per address is BLANK_CYC + max(dwell,1) cycles. A full sweep is 8× that.
- `done` and `wrap` are high for exactly the one cycle following the final DRIVE edge.
  - For `done`, `busy` falls on the same edge.
  - For `wrap`, `busy` stays high.
- The dwell counter is DWELL_W bits and counts down from the latched value; it never underflows.
- The blank counter is 4 bits.

## Structure
- Shared package `scan_pkg` holds:
  - FSM state encoding constants (IDLE, BLANK, DRIVE; 2-bit).
  - Direction constants (UP=0, DOWN=1).
  - The first/last-address constants (0, 7).
- One natural sub-module: `dwell_timer`. It is a loadable down-counter with a `load` input, a value input, and a `zero` flag. It is instantiated twice: once for dwell, once for blank.
- `E` and `busy` are decoded from state into registers, not driven combinationally.

## Test plan
- Reset checks:
  - Reset, then idle 5 cycles → `A`=0, `E`=0, `busy`=0, no pulses.
  - Assert `rst_n`=0 mid-DRIVE → outputs return to reset values immediately.
- One-shot up, dwell=3, BLANK_CYC=1:
  - `A` runs 0..7, each address has `E` high for 3 cycles with a 1-cycle gap.
  - `done` pulses 32 cycles after `start`.
  - `busy` falls with `done`; `A` stays at 7.
- Continuous down, dwell=2:
  - `A` runs 7..0, then 7 again.
  - `wrap` pulses once per 24 cycles; `done` never fires.
- dwell=0 behaves exactly as dwell=1.
  - Changing `dwell` mid-sweep from 2 to 9 has no effect until restart.
- Stop cases:
  - `stop` during DRIVE at `A`=4 → `E`=0 next cycle, `busy`=0, `A` holds 4, no `done`.
  - `start` and `stop` together in IDLE → stays IDLE.
- Invariant checker runs throughout all tests: `A` is never seen changing while `E`=1 in consecutive cycles.
  - `start` pulses while busy leave the sequence unchanged.

Source files
------------

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared constants for the decoder scan controller: FSM states, sweep direction
// and the address range of the 3-to-8 decoder being scanned.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [2:0] ADDR_FIRST = 3'd0;
    localparam logic [2:0] ADDR_LAST  = 3'd7;

    // The address a sweep begins on for a given direction.
    function automatic logic [2:0] start_addr(input logic dir);
        return (dir == DIR_DOWN) ? ADDR_LAST : ADDR_FIRST;
    endfunction

    function automatic logic [2:0] end_addr(input logic dir);
        return (dir == DIR_DOWN) ? ADDR_FIRST : ADDR_LAST;
    endfunction

    // 3-bit arithmetic makes the wrap 7->0 / 0->7 identical to a normal step.
    function automatic logic [2:0] step_addr(input logic [2:0] addr, input logic dir);
        return (dir == DIR_UP) ? addr + 3'd1 : addr - 3'd1;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan requester and the decoder scan controller,
// including the A/E lines that feed the 3-to-8 decoder.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               oneshot;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         A;
    logic               E;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, oneshot, dir, dwell,
        input  A, E, busy, done, wrap
    );

    modport slave (
        input  start, stop, oneshot, dir, dwell,
        output A, E, busy, done, wrap
    );
endinterface

// File: rtl/decoder_scan_ctrl_timer.sv
// Loadable saturating down-counter; zero is high once the count has run out.
// Used both for the per-address dwell time and for the blanking gap.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // Counting stops at zero so an idle timer never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Address generator for a 3-to-8 decoder: sweeps A through all eight outputs,
// holding E high for a dwell time per address with an E=0 gap around every A change.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder_scan_ctrl_if.slave bus
);

    // An out-of-range gap is clamped to what the 4-bit blank counter can express.
    localparam int BLANK_EFF = (BLANK_CYC < 1) ? 1 : ((BLANK_CYC > 15) ? 15 : BLANK_CYC);

    scan_state_t        state;
    logic               oneshot_lat;
    logic               dir_lat;
    logic [DWELL_W-1:0] dwell_lat;
    logic [2:0]         addr;
    logic               enable;
    logic               busy_r;
    logic               done_r;
    logic               wrap_r;

    logic               start_go;
    logic               at_last;
    logic               drive_end;
    logic               load_blank;
    logic               load_dwell;
    logic               blank_zero;
    logic               dwell_zero;
    logic [DWELL_W-1:0] dwell_load_val;
    logic [3:0]         blank_load_val;

    // Timers are loaded with (length - 1) so that the zero flag marks the final
    // cycle of a phase; a dwell of 0 therefore behaves exactly like a dwell of 1.
    always_comb begin
        start_go       = (state == ST_IDLE) && bus.start && !bus.stop;
        at_last        = (addr == end_addr(dir_lat));
        drive_end      = (state == ST_DRIVE) && dwell_zero && !bus.stop;
        load_blank     = start_go || (drive_end && !(at_last && oneshot_lat));
        load_dwell     = (state == ST_BLANK) && blank_zero && !bus.stop;
        dwell_load_val = (dwell_lat == '0) ? '0 : dwell_lat - DWELL_W'(1);
        blank_load_val = 4'(BLANK_EFF - 1);
    end

    dwell_timer #(
        .W(4)
    ) u_blank_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load_blank),
        .value(blank_load_val),
        .zero (blank_zero)
    );

    dwell_timer #(
        .W(DWELL_W)
    ) u_dwell_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load_dwell),
        .value(dwell_load_val),
        .zero (dwell_zero)
    );

    // Stop overrides everything; A is only ever stepped on an edge that also
    // drops E, so the decoder never sees an address change while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            oneshot_lat <= 1'b0;
            dir_lat     <= DIR_UP;
            dwell_lat   <= '0;
            addr        <= ADDR_FIRST;
            enable      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            if (bus.stop) begin
                state  <= ST_IDLE;
                enable <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        enable <= 1'b0;
                        if (start_go) begin
                            oneshot_lat <= bus.oneshot;
                            dir_lat     <= bus.dir;
                            dwell_lat   <= bus.dwell;
                            addr        <= start_addr(bus.dir);
                            state       <= ST_BLANK;
                            busy_r      <= 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        if (blank_zero) begin
                            state  <= ST_DRIVE;
                            enable <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (dwell_zero) begin
                            enable <= 1'b0;
                            if (at_last && oneshot_lat) begin
                                state  <= ST_IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                addr   <= step_addr(addr, dir_lat);
                                state  <= ST_BLANK;
                                wrap_r <= at_last;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        enable <= 1'b0;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.A    = addr;
    assign bus.E    = enable;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: a timeline model expands each sweep into
// its expected per-cycle outputs; a monitor compares the DUT against that queue.
module tb_decoder_scan_ctrl;

    localparam int DW    = 8;
    localparam int BLANK = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decoder_scan_ctrl_if #(.DWELL_W(DW)) bus ();

    decoder_scan_ctrl #(
        .DWELL_W  (DW),
        .BLANK_CYC(BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [2:0] a;
        logic       e;
        logic       busy;
        logic       done;
        logic       wrap;
    } obs_t;

    obs_t exp_q[$];
    obs_t trace[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   cont_run   = 1'b0;
    bit   lat_dir    = 1'b0;
    int   lat_dwell  = 1;
    obs_t last_exp   = '0;
    logic [2:0] prev_a = 3'd0;
    logic       prev_e = 1'b0;

    // A sweep is eight addresses, each BLANK gap cycles then max(dwell,1) enabled cycles.
    task automatic build_sweep(input bit dr, input int dw, input bit os, input bit wrap_first);
        int d;
        d = (dw < 1) ? 1 : dw;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] ad;
            ad = dr ? 3'(7 - i) : 3'(i);
            for (int b = 0; b < BLANK; b++)
                trace.push_back({ad, 1'b0, 1'b1, 1'b0, (wrap_first && i == 0 && b == 0)});
            for (int k = 0; k < d; k++)
                trace.push_back({ad, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        if (os) trace.push_back({(dr ? 3'd0 : 3'd7), 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t got;
        got = {bus.A, bus.E, bus.busy, bus.done, bus.wrap};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got A=%0d E=%b busy=%b done=%b wrap=%b, expected A=%0d E=%b busy=%b done=%b wrap=%b",
                     name, cyc, got.a, got.e, got.busy, got.done, got.wrap,
                     exp.a, exp.e, exp.busy, exp.done, exp.wrap);
        end
    endtask

    // Drives one clock's worth of inputs and queues what the outputs must be after the edge.
    task automatic applyStimulus(input bit st, input bit sp, input bit os, input bit dr, input int dw);
        obs_t nxt;
        @(negedge clk);
        #1;
        bus.start   = st;
        bus.stop    = sp;
        bus.oneshot = os;
        bus.dir     = dr;
        bus.dwell   = DW'(dw);
        if (sp) begin
            trace.delete();
            cont_run = 1'b0;
            nxt      = {last_exp.a, 4'b0};
        end else if (trace.size() == 0) begin
            if (st) begin
                build_sweep(dr, dw, os, 1'b0);
                cont_run  = !os;
                lat_dir   = dr;
                lat_dwell = dw;
                nxt       = trace.pop_front();
            end else begin
                nxt = {last_exp.a, 4'b0};
            end
        end else begin
            nxt = trace.pop_front();
        end
        if (trace.size() == 0 && cont_run) build_sweep(lat_dir, lat_dwell, 1'b0, 1'b1);
        last_exp = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        trace.delete();
        cont_run = 1'b0;
        last_exp = '0;
        #1;
        checkOutput("reset_immediate", '0);
        exp_q.push_back('0);
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            #1;
            exp_q.push_back('0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);
    endtask

    task automatic idleUntilDrive(input bit any_addr, input logic [2:0] addr, input bit os, input bit dr, input int dw);
        int n;
        n = 0;
        while (!(last_exp.e && (any_addr || last_exp.a == addr)) && n < 100) begin
            applyStimulus(1'b0, 1'b0, os, dr, dw);
            n++;
        end
        compared++;
        if (n >= 100) begin
            mismatched++;
            $display("[TB] FAIL drive_wait: waited %0d cycles, required E=1 at A=%0d", n, addr);
        end
    endtask

    // Monitor: pops one expectation per cycle and watches the A-stable-while-E invariant.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) checkOutput("trace", exp_q.pop_front());
            if (rst_n && prev_e && bus.E) begin
                compared++;
                if (bus.A !== prev_a) begin
                    mismatched++;
                    $display("[TB] FAIL invariant cycle %0d: A changed %0d -> %0d with E held 1, required stable",
                             cyc, prev_a, bus.A);
                end
            end
            prev_a = bus.A;
            prev_e = bus.E;
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.oneshot = 1'b0;
        bus.dir     = 1'b0;
        bus.dwell   = '0;

        $display("[TB] reset and idle");
        applyReset(3);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] one-shot up, dwell 3, ignored starts and config changes while busy");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3);
        for (int i = 0; i < 31; i++)
            applyStimulus(i % 7 == 3, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 20)));
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] continuous down, dwell 2");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2);
        repeat (60) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] dwell 0 one-shot");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);

        $display("[TB] dwell changed 2 -> 9 mid-sweep");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2);
        repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9);

        $display("[TB] stop during drive at address 4");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3);
        idleUntilDrive(1'b0, 3'd4, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] start with stop in idle");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] reset mid-drive");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        idleUntilDrive(1'b1, 3'd0, 1'b0, 1'b0, 4);
        applyReset(2);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] randomized sweeps");
        for (int r = 0; r < 40; r++) begin
            int len;
            len = int'($urandom_range(5, 50));
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 4)));
            for (int c = 0; c < len; c++)
                applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 7)));
        end
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
